// File: rtl/chunked_subtractor_pkg.sv
// rtl/chunked_subtractor_pkg.sv - shared types and sizing helpers for the chunked subtractor
package chunked_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // The counter must be able to hold MAX_CHUNKS itself, not just MAX_CHUNKS-1
    function automatic int calc_cw(input int max_chunks);
        return $clog2(max_chunks + 1);
    endfunction

endpackage

// File: rtl/chunked_subtractor_if.sv
// rtl/chunked_subtractor_if.sv - operand-in / result-out handshake bundle
interface chunked_subtractor_if
    import chunked_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = calc_cw(4)
);
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic             in_last;
    logic             bin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             diff_last;
    logic             bout;
    logic             zero;
    logic             len_err;
    logic [CW-1:0]    chunk_cnt;

    modport master (
        output in_valid, in_first, in_last, bin, a, b, out_ready,
        input  in_ready, out_valid, diff, diff_last, bout, zero, len_err, chunk_cnt
    );

    modport slave (
        input  in_valid, in_first, in_last, bin, a, b, out_ready,
        output in_ready, out_valid, diff, diff_last, bout, zero, len_err, chunk_cnt
    );

endinterface

// File: rtl/chunked_subtractor_chunk_sub.sv
// rtl/chunked_subtractor_chunk_sub.sv - one chunk of A - B - borrow, WIDTH+1 bits wide
module chunk_sub
    import chunked_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bsel,
    output logic [WIDTH-1:0] o_d,
    output logic             o_bb,
    output logic             o_is_zero
);

    assign {o_bb, o_d} = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_bsel};
    assign o_is_zero   = (o_d == '0);

endmodule

// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - streamed wide subtractor with borrow carried across chunks
module chunked_subtractor
    import chunked_sub_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MAX_CHUNKS = 4,
    parameter int CW         = calc_cw(MAX_CHUNKS)
) (
    input logic                clk,
    input logic                rst_n,
    chunked_subtractor_if.slave bus
);

    state_e           r_state;
    logic             r_borrow;
    logic             r_zacc;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_diff_last;
    logic             r_bout;
    logic             r_zero;
    logic             r_len_err;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_process;
    logic             w_restart;
    logic             w_ovf;
    logic             w_bsel;
    logic [WIDTH-1:0] w_d;
    logic             w_bb;
    logic             w_is_zero;
    logic             w_zacc_next;
    logic [CW:0]      w_cnt_next;

    chunk_sub #(.WIDTH(WIDTH)) u_chunk_sub (
        .i_a       (bus.a),
        .i_b       (bus.b),
        .i_bsel    (w_bsel),
        .o_d       (w_d),
        .o_bb      (w_bb),
        .o_is_zero (w_is_zero)
    );

    assign w_in_ready  = !r_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;
    // Non-first chunks arriving in IDLE are consumed silently
    assign w_process   = w_accept && (bus.in_first || (r_state == BUSY));
    assign w_restart   = bus.in_first && (r_state == BUSY);
    assign w_bsel      = bus.in_first ? bus.bin : r_borrow;
    // One extra bit so MAX_CHUNKS+1 is representable for the overflow compare
    assign w_cnt_next  = bus.in_first ? (CW+1)'(1) : ({1'b0, r_cnt} + (CW+1)'(1));
    assign w_ovf       = (w_cnt_next > (CW+1)'(MAX_CHUNKS));
    assign w_zacc_next = (bus.in_first || r_zacc) && w_is_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_borrow <= 1'b0;
            r_zacc   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_process) begin
            r_state  <= (w_ovf || bus.in_last) ? IDLE : BUSY;
            r_borrow <= w_bb;
            r_zacc   <= w_zacc_next;
            r_cnt    <= w_ovf ? CW'(MAX_CHUNKS) : w_cnt_next[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_diff_last <= 1'b0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
            r_len_err   <= 1'b0;
        end else if (w_process) begin
            r_out_valid <= 1'b1;
            r_diff      <= w_d;
            r_diff_last <= bus.in_last || w_ovf;
            r_bout      <= w_bb;
            r_zero      <= bus.in_last && !w_ovf && w_zacc_next;
            r_len_err   <= w_ovf || w_restart;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.diff_last = r_diff_last;
    assign bus.bout      = r_bout;
    assign bus.zero      = r_zero;
    assign bus.len_err   = r_len_err;
    assign bus.chunk_cnt = r_cnt;

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb/tb_chunked_subtractor.sv - directed-vector bench for chunked_subtractor
module tb_chunked_subtractor;

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    chunked_subtractor_if #(.WIDTH(8), .CW(3)) bus ();

    chunked_subtractor #(.WIDTH(8), .MAX_CHUNKS(4), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out_valid, diff[7:0], bout, zero, diff_last, len_err}
    function automatic logic [12:0] obs();
        return {bus.out_valid, bus.diff, bus.bout, bus.zero, bus.diff_last, bus.len_err};
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic first, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.bin = bin;
        bus.in_first = first; bus.in_last = last; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vecs++; errs++;
            $display("FAIL send_timeout in_ready stuck at %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({obs(), bus.chunk_cnt, bus.in_ready} !== {13'h0, 3'd0, 1'b1}) begin
            errs++;
            $display("FAIL reset_state got %h required %h", {obs(), bus.chunk_cnt, bus.in_ready}, {13'h0, 3'd0, 1'b1});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [12:0] o;
        send(8'h05, 8'h03, 1'b0, 1'b1, 1'b1);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h02, 4'b0010}) begin
            errs++; $display("FAIL single_05_03 got %h required %h", o, {1'b1, 8'h02, 4'b0010});
        end
        vecs++;
        if (bus.chunk_cnt !== 3'd1) begin
            errs++; $display("FAIL single_cnt got %0d required 1", bus.chunk_cnt);
        end
        send(8'h03, 8'h05, 1'b0, 1'b1, 1'b1);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'hFE, 4'b1010}) begin
            errs++; $display("FAIL single_borrow got %h required %h", o, {1'b1, 8'hFE, 4'b1010});
        end
        send(8'h05, 8'h03, 1'b1, 1'b1, 1'b1);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h01, 4'b0010}) begin
            errs++; $display("FAIL single_bin got %h required %h", o, {1'b1, 8'h01, 4'b0010});
        end
        @(negedge clk);
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL valid_clear got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_two_chunk();
        logic [12:0] o;
        send(8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'hFF, 4'b1000}) begin
            errs++; $display("FAIL two_c0 got %h required %h", o, {1'b1, 8'hFF, 4'b1000});
        end
        send(8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h00, 4'b0010}) begin
            errs++; $display("FAIL two_c1 got %h required %h", o, {1'b1, 8'h00, 4'b0010});
        end
    endtask

    task automatic test_equal_stall();
        logic [12:0] o;
        send(8'h56, 8'h56, 1'b0, 1'b1, 1'b0);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h00, 4'b0000}) begin
            errs++; $display("FAIL eq_c0 got %h required %h", o, {1'b1, 8'h00, 4'b0000});
        end
        send(8'h34, 8'h34, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.a = 8'h12; bus.b = 8'h12; bus.bin = 1'b0;
        bus.in_first = 1'b0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs();
            vecs++;
            if ({o, bus.in_ready} !== {1'b1, 8'h00, 4'b0000, 1'b0}) begin
                errs++;
                $display("FAIL eq_stall%0d got %h required %h", i, {o, bus.in_ready}, {1'b1, 8'h00, 4'b0000, 1'b0});
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h00, 4'b0110}) begin
            errs++; $display("FAIL eq_last got %h required %h", o, {1'b1, 8'h00, 4'b0110});
        end
    endtask

    task automatic test_max_chunks();
        logic [12:0] o;
        logic [12:0] exp_tab [0:5];
        exp_tab[0] = {1'b1, 8'h0F, 4'b0000};
        exp_tab[1] = {1'b1, 8'h10, 4'b0000};
        exp_tab[2] = {1'b1, 8'h11, 4'b0000};
        exp_tab[3] = {1'b1, 8'h12, 4'b0000};
        exp_tab[4] = {1'b1, 8'h13, 4'b0011};
        exp_tab[5] = {1'b0, 8'h13, 4'b0011};
        for (int i = 0; i < 6; i++) begin
            send(8'h10 + 8'(i), 8'h01, 1'b0, (i == 0), 1'b0);
            @(negedge clk); o = obs();
            vecs++;
            if (o !== exp_tab[i]) begin
                errs++; $display("FAIL max_c%0d got %h required %h", i, o, exp_tab[i]);
            end
            if (i == 3) begin
                vecs++;
                if (bus.chunk_cnt !== 3'd4) begin
                    errs++; $display("FAIL max_cnt got %0d required 4", bus.chunk_cnt);
                end
            end
        end
        send(8'h07, 8'h02, 1'b0, 1'b1, 1'b1);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h05, 4'b0010}) begin
            errs++; $display("FAIL max_next got %h required %h", o, {1'b1, 8'h05, 4'b0010});
        end
    endtask

    task automatic test_reset_midstream();
        logic [12:0] o;
        send(8'h56, 8'h00, 1'b0, 1'b1, 1'b0);
        send(8'h34, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({obs(), bus.chunk_cnt} !== 16'h0) begin
            errs++; $display("FAIL midreset_state got %h required 0000", {obs(), bus.chunk_cnt});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h12, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL midreset_drop got %b required 0", bus.out_valid);
        end
        send(8'h10, 8'h10, 1'b0, 1'b1, 1'b1);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h00, 4'b0110}) begin
            errs++; $display("FAIL midreset_fresh got %h required %h", o, {1'b1, 8'h00, 4'b0110});
        end
    endtask

    task automatic test_restart();
        logic [12:0] o;
        send(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h01, 4'b0000}) begin
            errs++; $display("FAIL restart_c0 got %h required %h", o, {1'b1, 8'h01, 4'b0000});
        end
        send(8'h09, 8'h04, 1'b0, 1'b1, 1'b1);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h05, 4'b0011}) begin
            errs++; $display("FAIL restart_new got %h required %h", o, {1'b1, 8'h05, 4'b0011});
        end
        send(8'h09, 8'h04, 1'b0, 1'b1, 1'b1);
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'h05, 4'b0010}) begin
            errs++; $display("FAIL restart_after got %h required %h", o, {1'b1, 8'h05, 4'b0010});
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] o;
        @(negedge clk);
        bus.a = 8'h00; bus.b = 8'h01; bus.bin = 1'b0;
        bus.in_first = 1'b1; bus.in_last = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk); o = obs();
        vecs++;
        if (o !== {1'b1, 8'hFF, 4'b1000}) begin
            errs++; $display("FAIL b2b_c0 got %h required %h", o, {1'b1, 8'hFF, 4'b1000});
        end
        bus.a = 8'h03; bus.b = 8'h01; bus.in_first = 1'b0; bus.in_last = 1'b1;
        @(negedge clk); o = obs();
        bus.in_valid = 1'b0;
        vecs++;
        if (o !== {1'b1, 8'h01, 4'b0010}) begin
            errs++; $display("FAIL b2b_c1 got %h required %h", o, {1'b1, 8'h01, 4'b0010});
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.bin       = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b1;
        test_reset();
        test_single();
        test_two_chunk();
        test_equal_stall();
        test_max_chunks();
        test_reset_midstream();
        test_restart();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
